pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//  Program-counter and return-address stack for the single-cycle MIPS-style datapath.
//  Consumes the decode controller's pc_src, stack_push and stack_pop plus the current instruction word.
//  Produces the next instruction address that drives instruction memory.
//  Owns the hardware call stack used by jsb/ret, and detects the halt word.
// PARAMETERS
//  ADDR_W       12  width of PC / instruction address
//  STACK_DEPTH  8   return-address entries (power of 2, >=2)
//  OFFSET_W     8   signed branch offset width, instruction[OFFSET_W-1:0]
//  RESET_PC     0   PC value loaded on reset
// PORTS
//  clk          in   1            single clock, all state on posedge
//  rst          in   1            synchronous, active-high reset
//  instruction  in   19           current instruction word (combinational from imem[pc])
//  pc_src       in   2            00 seq, 01 jump abs, 10 ret, 11 branch taken
//  stack_push   in   1            push return address (jsb)
//  stack_pop    in   1            pop return address (ret)
//  pc           out  ADDR_W       current instruction address
//  stack_depth  out  clog2(D)+1   valid entries on stack, 0..STACK_DEPTH
//  overflow     out  1            sticky: push attempted while full
//  underflow    out  1            sticky: pop attempted while empty
//  halted       out  1            sticky: halt word 19'h7FFFF executed
// BEHAVIOUR
//  Reset (rst=1 at posedge): pc=RESET_PC, stack_depth=0, overflow=underflow=halted=0; stack RAM not cleared.
//  pc_plus1 = pc+1, modulo 2^ADDR_W (wraps from all-ones to 0).
//  Next PC, applied at posedge (one-cycle latency, no bubbles):
//   00 -> pc_plus1
//   01 -> instruction[ADDR_W-1:0] (absolute)
//   10 -> top of stack (entry depth-1)
//   11 -> pc_plus1 + sign_ext(instruction[OFFSET_W-1:0]), truncated to ADDR_W
//  Push: when stack_push=1 and depth<STACK_DEPTH, write pc_plus1 at entry[depth], depth++.
//   Jump (pc_src=01) is taken in the same cycle.
//  Push when full: no write, depth unchanged, overflow<=1, jump still taken.
//  Pop: when stack_pop=1 and depth>0, pc<=entry[depth-1], depth--.
//  Pop when empty: pc<=pc_plus1, depth stays 0, underflow<=1.
//  push and pop in the same cycle (illegal from controller): stack unchanged, pc<=pc_plus1,
//   overflow<=1 and underflow<=1.
//  pc_src=10 without stack_pop, or stack_pop with pc_src!=10: stack_pop governs.
//   pop taken -> pc=popped value; otherwise pc_src=10 treated as 00.
//  Halt: instruction==19'h7FFFF and !halted -> halted<=1, pc holds.
//  While halted, pc and stack are frozen and all inputs are ignored until rst.
//  Sticky flags clear only on rst.
//  rst has priority over every event in the same cycle, including halt and push.
// STRUCTURE
//  pc_defs.vh (shared include): PC_SEQ/PC_JMP/PC_RET/PC_BR encodings, HALT_WORD,
//   opcode field positions; the controller is to include the same file.
//  Sub-module return_stack: DEPTH x ADDR_W register file with depth counter,
//   push/pop/full/empty; exposes top and flag-update strobes.
//  Top holds the PC register, next-PC mux, branch adder and halt logic.
// TESTING
//  Sequential: rst, pc_src=00 for 5 cycles -> pc 0,1,2,3,4,5; ADDR_W all-ones +1 -> 0.
//  Branch: pc=10, pc_src=11, instr[7:0]=8'hFC -> pc=7; instr[7:0]=8'h05 -> pc=16.
//  Call/return: pc=20, pc_src=01+push, target 100 -> pc=100, depth=1;
//   next cycle pc_src=10+pop -> pc=21, depth=0.
//  Nested calls to STACK_DEPTH, then one more push -> overflow=1, depth=8, jump taken;
//   8 pops return in LIFO order.
//  Pop on empty at pc=30 -> pc=31, underflow=1; push+pop together -> stack unchanged, both flags set.
//  Halt word at pc=40 -> halted=1, pc stays 40 for 10 cycles despite pc_src=01;
//   rst mid-halt -> pc=RESET_PC, all flags 0.

Source files
------------

// File: rtl/pc_stack_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_stack_unit_pkg
// Brief   : Shared encodings for the PC / return-stack unit and its controller
// Revision: 1.0  initial release
// ============================================================================
package pc_stack_unit_pkg;

  // Width of an instruction word
  localparam int INSTR_W = 19;

  // pc_src encodings driven by the decode controller
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_JMP = 2'b01;
  localparam logic [1:0] PC_RET = 2'b10;
  localparam logic [1:0] PC_BR  = 2'b11;

  // Instruction word that stops the machine
  localparam logic [INSTR_W-1:0] HALT_WORD = 19'h7FFFF;

  // True when the word is the halt instruction
  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr == HALT_WORD;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_stack_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : pc_stack_unit_if
// Brief   : Controller <-> PC/stack unit signal bundle
// Revision: 1.0  initial release
// ============================================================================
interface pc_stack_unit_if
  import pc_stack_unit_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DEPTH_W = 4
);
  logic [INSTR_W-1:0] instruction;
  logic [1:0]         pc_src;
  logic               stack_push;
  logic               stack_pop;
  logic [ADDR_W-1:0]  pc;
  logic [DEPTH_W-1:0] stack_depth;
  logic               overflow;
  logic               underflow;
  logic               halted;

  // Controller / instruction-fetch side
  modport master (
    output instruction, pc_src, stack_push, stack_pop,
    input  pc, stack_depth, overflow, underflow, halted
  );

  // PC / stack unit side
  modport slave (
    input  instruction, pc_src, stack_push, stack_pop,
    output pc, stack_depth, overflow, underflow, halted
  );
endinterface
`default_nettype wire

// File: rtl/pc_stack_unit_return_stack.sv
`default_nettype none
// ============================================================================
// Module  : pc_stack_unit_return_stack
// Brief   : STACK_DEPTH x ADDR_W return-address register file with depth
//           counter; reports taken pops and overflow/underflow strobes.
// Revision: 1.0  initial release
// ============================================================================
module pc_stack_unit_return_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 8
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           push_i,
  input  wire logic                           pop_i,
  input  wire logic [ADDR_W-1:0]              wdata_i,
  output logic      [ADDR_W-1:0]              top_o,
  output logic      [$clog2(STACK_DEPTH):0]   depth_o,
  output logic                                pop_taken_o,
  output logic                                ovf_stb_o,
  output logic                                unf_stb_o
);
  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               full_w, empty_w;
  logic               do_push_w, do_pop_w;
  logic [PTR_W-1:0]   wr_ptr_w, rd_ptr_w;
  logic [ADDR_W-1:0]  mem_w [STACK_DEPTH];

  assign full_w    = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty_w   = (depth_q == '0);
  // Simultaneous push and pop is illegal: neither takes effect, both flag.
  assign do_push_w = push_i & ~pop_i & ~full_w;
  assign do_pop_w  = pop_i & ~push_i & ~empty_w;
  assign wr_ptr_w  = depth_q[PTR_W-1:0];
  assign rd_ptr_w  = wr_ptr_w - PTR_W'(1);

  assign top_o       = mem_w[rd_ptr_w];
  assign depth_o     = depth_q;
  assign pop_taken_o = do_pop_w;
  assign ovf_stb_o   = push_i & (full_w | pop_i);
  assign unf_stb_o   = pop_i & (empty_w | push_i);

  // Depth counter next state
  always_comb begin
    depth_d = depth_q;
    if (do_push_w)     depth_d = depth_q + DEPTH_W'(1);
    else if (do_pop_w) depth_d = depth_q - DEPTH_W'(1);
  end

  // Depth counter register
  always_ff @(posedge clk) begin
    if (rst) depth_q <= '0;
    else     depth_q <= depth_d;
  end

  // Entry storage; contents are deliberately left untouched by reset
  for (genvar i = 0; i < STACK_DEPTH; i++) begin : g_entry
    logic [ADDR_W-1:0] entry_q;
    // Capture the return address into the slot at the current depth
    always_ff @(posedge clk) begin
      if (do_push_w && (wr_ptr_w == PTR_W'(i))) entry_q <= wdata_i;
    end
    assign mem_w[i] = entry_q;
  end

endmodule
`default_nettype wire

// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module  : pc_stack_unit
// Brief   : Program counter, next-PC selection, branch adder, halt detection
//           and hardware return-address stack for jsb/ret.
//           Requires ADDR_W > OFFSET_W and ADDR_W <= 19.
// Revision: 1.0  initial release
// ============================================================================
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter int          STACK_DEPTH = 8,
  parameter int          OFFSET_W    = 8,
  parameter logic [11:0] RESET_PC    = 12'd0
) (
  input wire logic       clk,
  input wire logic       rst,
  pc_stack_unit_if.slave bus
);
  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               halted_q, halted_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic [ADDR_W-1:0]  pc_plus1_w, branch_w, offset_w, top_w;
  logic [DEPTH_W-1:0] depth_w;
  logic               halt_evt_w, active_w, push_w, pop_w;
  logic               pop_taken_w, ovf_stb_w, unf_stb_w;

  assign pc_plus1_w = pc_q + ADDR_W'(1);
  assign offset_w   = {{(ADDR_W-OFFSET_W){bus.instruction[OFFSET_W-1]}},
                       bus.instruction[OFFSET_W-1:0]};
  assign branch_w   = pc_plus1_w + offset_w;

  // The halt cycle itself and every cycle after it leave PC and stack alone
  assign halt_evt_w = ~halted_q & is_halt(bus.instruction);
  assign active_w   = ~halted_q & ~halt_evt_w;
  assign push_w     = active_w & bus.stack_push;
  assign pop_w      = active_w & bus.stack_pop;

  pc_stack_unit_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_w),
    .pop_i       (pop_w),
    .wdata_i     (pc_plus1_w),
    .top_o       (top_w),
    .depth_o     (depth_w),
    .pop_taken_o (pop_taken_w),
    .ovf_stb_o   (ovf_stb_w),
    .unf_stb_o   (unf_stb_w)
  );

  // Next-PC select: stack_pop overrides pc_src; a failed or illegal pop falls through to pc+1
  always_comb begin
    pc_d = pc_plus1_w;
    if (!active_w)        pc_d = pc_q;
    else if (pop_taken_w) pc_d = top_w;
    else if (pop_w)       pc_d = pc_plus1_w;
    else begin
      case (bus.pc_src)
        PC_JMP:  pc_d = bus.instruction[ADDR_W-1:0];
        PC_BR:   pc_d = branch_w;
        default: pc_d = pc_plus1_w;
      endcase
    end
  end

  // Sticky status flags accumulate until reset
  always_comb begin
    halted_d    = halted_q | halt_evt_w;
    overflow_d  = overflow_q | ovf_stb_w;
    underflow_d = underflow_q | unf_stb_w;
  end

  // PC and status registers; reset wins over every same-cycle event
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= ADDR_W'(RESET_PC);
      halted_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.stack_depth = depth_w;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_stack_unit
// Brief   : Directed, table-driven self-checking bench for pc_stack_unit
// Revision: 1.0  initial release
// ============================================================================
module tb_pc_stack_unit;
  import pc_stack_unit_pkg::*;

  typedef struct packed {
    logic        rst;
    logic [18:0] instr;
    logic [1:0]  src;
    logic        push;
    logic        pop;
    logic [11:0] pc;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;
    logic        halt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pc_stack_unit_if #(.ADDR_W(12), .DEPTH_W(4)) bus ();

  pc_stack_unit #(
    .ADDR_W      (12),
    .STACK_DEPTH (8),
    .OFFSET_W    (8),
    .RESET_PC    (12'd0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void add(input logic r, input logic [18:0] ins, input logic [1:0] s,
                              input logic pu, input logic po, input logic [11:0] p,
                              input logic [3:0] d, input logic o, input logic u, input logic h);
    vec_t v;
    v = '{rst: r, instr: ins, src: s, push: pu, pop: po, pc: p, depth: d,
          ovf: o, unf: u, halt: h};
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, then compare every output after the edge
  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    rst             = v.rst;
    bus.instruction = v.instr;
    bus.pc_src      = v.src;
    bus.stack_push  = v.push;
    bus.stack_pop   = v.pop;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pc !== v.pc || bus.stack_depth !== v.depth || bus.overflow !== v.ovf ||
        bus.underflow !== v.unf || bus.halted !== v.halt) begin
      errors++;
      $display("FAIL %s[%0d]: got pc=%0d depth=%0d ovf=%b unf=%b halt=%b, want pc=%0d depth=%0d ovf=%b unf=%b halt=%b",
               tag, idx, bus.pc, bus.stack_depth, bus.overflow, bus.underflow, bus.halted,
               v.pc, v.depth, v.ovf, v.unf, v.halt);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.instruction = '0;
    bus.pc_src = PC_SEQ;
    bus.stack_push = 1'b0;
    bus.stack_pop = 1'b0;

    // Reset, then sequential fetch 1..5
    add(1, 0, PC_SEQ, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) add(0, 0, PC_SEQ, 0, 0, 12'(i), 0, 0, 0, 0);
    // Branches from pc=10: -4 and +5 relative to pc+1
    add(0, 19'd10,     PC_JMP, 0, 0, 10, 0, 0, 0, 0);
    add(0, 19'h000FC,  PC_BR,  0, 0,  7, 0, 0, 0, 0);
    add(0, 19'd10,     PC_JMP, 0, 0, 10, 0, 0, 0, 0);
    add(0, 19'h00005,  PC_BR,  0, 0, 16, 0, 0, 0, 0);
    // Call from 20 to 100, return to 21
    add(0, 19'd20,  PC_JMP, 0, 0,  20, 0, 0, 0, 0);
    add(0, 19'd100, PC_JMP, 1, 0, 100, 1, 0, 0, 0);
    add(0, 19'd0,   PC_RET, 0, 1,  21, 0, 0, 0, 0);
    // Nest eight calls: first from 21, then from 200,210,...,260
    for (int k = 0; k < 8; k++)
      add(0, 19'(200 + 10*k), PC_JMP, 1, 0, 12'(200 + 10*k), 4'(k + 1), 0, 0, 0);
    // Ninth push: overflow, jump still taken, depth stays 8
    add(0, 19'd500, PC_JMP, 1, 0, 500, 8, 1, 0, 0);
    // Unwind in LIFO order: 261,251,...,201 then 22
    for (int k = 7; k >= 0; k--)
      add(0, 0, PC_RET, 0, 1, (k == 0) ? 12'd22 : 12'(200 + 10*(k-1) + 1), 4'(k), 1, 0, 0);
    // Pop on empty at 30
    add(1, 0, PC_SEQ, 0, 0, 0, 0, 0, 0, 0);
    add(0, 19'd30, PC_JMP, 0, 0, 30, 0, 0, 0, 0);
    add(0, 19'd0,  PC_RET, 0, 1, 31, 0, 0, 1, 0);
    // Push+pop together leaves the stack holding the return address 1
    add(1, 0, PC_SEQ, 0, 0, 0, 0, 0, 0, 0);
    add(0, 19'd50, PC_JMP, 1, 0, 50, 1, 0, 0, 0);
    add(0, 19'd80, PC_JMP, 1, 1, 51, 1, 1, 1, 0);
    add(0, 19'd0,  PC_RET, 0, 1,  1, 0, 1, 1, 0);
    // pc_src=ret without pop behaves as sequential
    add(0, 19'd0,  PC_RET, 0, 0,  2, 0, 1, 1, 0);
    // PC wraps from all-ones to zero
    add(0, 19'd4095, PC_JMP, 0, 0, 4095, 0, 1, 1, 0);
    add(0, 19'd0,    PC_SEQ, 0, 0,    0, 0, 1, 1, 0);
    // Reset beats a simultaneous push/jump
    add(1, 19'd77, PC_JMP, 1, 0, 0, 0, 0, 0, 0);
    // Halt at 40, then ten cycles of ignored push/jump, then reset
    add(0, 19'd40,    PC_JMP, 0, 0, 40, 0, 0, 0, 0);
    add(0, HALT_WORD, PC_SEQ, 0, 0, 40, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) add(0, 19'd100, PC_JMP, 1, 0, 40, 0, 0, 0, 1);
    add(1, 0, PC_SEQ, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) apply(vecs[i], "table", i);

    // Halt with a non-empty stack: halt-cycle push ignored, pops ignored while halted
    v = '{rst: 0, instr: 19'd60, src: PC_JMP, push: 1, pop: 0, pc: 60, depth: 1, ovf: 0, unf: 0, halt: 0};
    apply(v, "halt_seq", 0);
    v = '{rst: 0, instr: HALT_WORD, src: PC_JMP, push: 1, pop: 0, pc: 60, depth: 1, ovf: 0, unf: 0, halt: 1};
    apply(v, "halt_seq", 1);
    for (int i = 0; i < 3; i++) begin
      v = '{rst: 0, instr: 19'd0, src: PC_RET, push: 0, pop: 1, pc: 60, depth: 1, ovf: 0, unf: 0, halt: 1};
      apply(v, "halt_seq", 2 + i);
    end
    v = '{rst: 1, instr: 19'd0, src: PC_SEQ, push: 0, pop: 0, pc: 0, depth: 0, ovf: 0, unf: 0, halt: 0};
    apply(v, "halt_seq", 5);

    // stack_pop governs even when pc_src is sequential
    v = '{rst: 0, instr: 19'd70, src: PC_JMP, push: 1, pop: 0, pc: 70, depth: 1, ovf: 0, unf: 0, halt: 0};
    apply(v, "pop_seq", 0);
    v = '{rst: 0, instr: 19'd0, src: PC_SEQ, push: 0, pop: 1, pc: 1, depth: 0, ovf: 0, unf: 0, halt: 0};
    apply(v, "pop_seq", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
